fifo_frame_reader: RTL and testbench

- Downstream consumer of the 14-bit sample FIFO: drains it in fixed-length bursts and emits framed beats on a valid/ready stream to the packetiser.
- Starts a burst when FIFO level reaches BURST_LEN.
- Sends a short frame on timeout or flush, so residual samples never stall in the FIFO.
- Absorbs the FIFO's 1-cycle read latency and downstream backpressure with a 2-entry output buffer.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/frame_skid_buf.sv | 66 ++++++
 rtl/fifo_frame_reader.sv | 159 +++++++++++++++
 tb/tb_fifo_frame_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the sample-FIFO frame reader: default widths and the
// reader FSM state encoding.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 14;
    localparam int DEF_FIFO_DEPTH = 64;
    localparam int COUNT_W        = $clog2(DEF_FIFO_DEPTH);
    localparam int LEVEL_W        = COUNT_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        WAIT_OUT = 2'd2
    } state_t;

endpackage

// File: rtl/frame_skid_buf.sv
// Two-entry valid/ready buffer carrying {data, sof, eof}. The count output lets
// the producer meter its reads so the buffer never overflows.
module frame_skid_buf #(
    parameter int DATA_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_sof,
    input  logic                  in_eof,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eof,
    input  logic                  out_ready,
    output logic [1:0]            count
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sof;
        logic                  eof;
    } beat_t;

    beat_t mem [2];
    beat_t head;
    logic  wr_ptr;
    logic  rd_ptr;
    logic  push;
    logic  pop;

    assign push      = in_valid;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign head      = mem[rd_ptr];

    // Outputs are forced to zero while empty so nothing stale leaks after reset.
    assign out_data = out_valid ? head.data : '0;
    assign out_sof  = out_valid & head.sof;
    assign out_eof  = out_valid & head.eof;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{data: in_data, sof: in_sof, eof: in_eof};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == 2'd2));
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && count == 2'd0));

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains the sample FIFO in bursts (or short frames on flush/timeout) and emits
// framed beats on a valid/ready stream through a two-entry output buffer.
module fifo_frame_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int BURST_LEN   = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fifo_empty,
    input  logic                          fifo_full,
    input  logic [$clog2(FIFO_DEPTH)-1:0] fifo_count,
    input  logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_en,
    input  logic                          flush,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_sof,
    output logic                          m_eof,
    output logic                          busy
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int LW = CW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    localparam logic [LW-1:0] BURST_L = LW'(BURST_LEN);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] ONE_L   = LW'(1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);

    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] level;
    logic [LW-1:0] frame_len;
    logic [LW-1:0] reads_left;
    logic [LW-1:0] beats_left;
    logic [LW-1:0] trig_len;
    logic [TW-1:0] tcnt;
    logic          trigger;
    logic          inflight;
    logic          inflight_sof;
    logic          inflight_eof;
    logic [1:0]    buf_count;
    logic [1:0]    used;
    logic          credit_ok;
    logic          pop;

    // A full FIFO reports count 0, so the full flag supplies the top value.
    assign level = fifo_full ? DEPTH_L : {1'b0, fifo_count};
    assign pop   = m_valid & m_ready;
    assign busy  = (state != IDLE);

    // A beat leaving this cycle frees a slot, which keeps one read per cycle
    // flowing when downstream is always ready.
    assign used      = buf_count + {1'b0, inflight};
    assign credit_ok = (used < 2'd2) || pop;

    always_comb begin
        trigger  = 1'b0;
        trig_len = '0;
        if (level >= BURST_L) begin
            trigger  = 1'b1;
            trig_len = BURST_L;
        end else if (level != '0 && (flush || tcnt == TO_LAST)) begin
            trigger  = 1'b1;
            trig_len = level;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                rd_en = (reads_left != '0) && !fifo_empty && credit_ok;
                if (rd_en && reads_left == ONE_L) begin
                    state_nxt = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (pop && beats_left == ONE_L) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            frame_len    <= '0;
            reads_left   <= '0;
            beats_left   <= '0;
            tcnt         <= '0;
            inflight     <= 1'b0;
            inflight_sof <= 1'b0;
            inflight_eof <= 1'b0;
        end else begin
            state <= state_nxt;
            // Frame position is known at read time; it travels with the read.
            inflight     <= rd_en;
            inflight_sof <= rd_en && (reads_left == frame_len);
            inflight_eof <= rd_en && (reads_left == ONE_L);
            if (state == IDLE) begin
                if (trigger) begin
                    frame_len  <= trig_len;
                    reads_left <= trig_len;
                    beats_left <= trig_len;
                    tcnt       <= '0;
                end else if (level == '0) begin
                    tcnt <= '0;
                end else begin
                    tcnt <= tcnt + TO_ONE;
                end
            end else begin
                tcnt <= '0;
                if (rd_en) begin
                    reads_left <= reads_left - ONE_L;
                end
                if (pop) begin
                    beats_left <= beats_left - ONE_L;
                end
            end
        end
    end

    frame_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (inflight),
        .in_data  (rd_data),
        .in_sof   (inflight_sof),
        .in_eof   (inflight_eof),
        .out_valid(m_valid),
        .out_data (m_data),
        .out_sof  (m_sof),
        .out_eof  (m_eof),
        .out_ready(m_ready),
        .count    (buf_count)
    );

    a_no_read_in_idle : assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_en && state == IDLE));

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: a behavioural sample FIFO feeds the reader and a
// scoreboard checks every accepted beat against hand-computed frames.
module tb_fifo_frame_reader;
    import fifo_pkg::*;

    localparam int DW    = 14;
    localparam int DEPTH = 64;
    localparam int W     = DW + 2;

    // Handshake: a beat moves on a rising edge where m_valid && m_ready; while
    // m_valid is high and m_ready low the beat (data, sof, eof) must not change.

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_full = 1'b0;
    logic [5:0]    fifo_count = '0;
    logic [DW-1:0] rd_data = '0;
    logic          rd_en;
    logic          flush = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_sof;
    logic          m_eof;
    logic          busy;

    always #5 clk = ~clk;

    fifo_frame_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .fifo_count(fifo_count),
        .rd_data   (rd_data),
        .rd_en     (rd_en),
        .flush     (flush),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sof     (m_sof),
        .m_eof     (m_eof),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_range(string name, int act, int lo, int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- FIFO model ----------------
    logic [DW-1:0] fifo_q[$];
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_val = '0;
    int            rd_cnt = 0;
    int            rd_empty_err = 0;
    int            wr_over_err = 0;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_cnt++;
            if (fifo_q.size() == 0) rd_empty_err++;
            else rd_data <= fifo_q.pop_front();
        end
        if (wr_en) begin
            if (fifo_q.size() < DEPTH) fifo_q.push_back(wr_val);
            else wr_over_err++;
        end
        fifo_empty <= (fifo_q.size() == 0);
        fifo_full  <= (fifo_q.size() == DEPTH);
        fifo_count <= 6'(fifo_q.size());
    end

    task automatic write_words(int first, int num);
        for (int i = 0; i < num; i++) begin
            wr_en  = 1'b1;
            wr_val = DW'(first + i);
            step();
        end
        wr_en = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];

    task automatic push_beat(logic [DW-1:0] d, logic sof, logic eof);
        exp_q.push_back({d, sof, eof});
    endtask

    task automatic expect_frame(int first, int len);
        for (int i = 0; i < len; i++) begin
            push_beat(DW'(first + i), (i == 0), (i == len - 1));
        end
    endtask

    task automatic wait_drain(int max_cyc, string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else begin
            $display("FAIL %s: %0d beats outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    logic         hold_v = 1'b0;
    logic [W-1:0] hold_b = '0;
    int           beats_seen = 0;
    int           last_sof_cyc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) check("stall_hold", 32'({m_valid, m_data, m_sof, m_eof}), 32'({1'b1, hold_b}));
            hold_v = 1'b0;
            if (m_valid) begin
                if (m_ready) begin
                    beats_seen++;
                    if (m_sof) last_sof_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got data 0x%0h sof %0b eof %0b expected no beat",
                                 m_data, m_sof, m_eof);
                    end else begin
                        check("beat", 32'({m_data, m_sof, m_eof}), 32'(exp_q.pop_front()));
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_b = {m_data, m_sof, m_eof};
                end
            end
        end
    end

    logic toggle_on = 1'b0;
    always @(posedge clk) begin
        #1;
        m_ready = toggle_on ? ~m_ready : 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int c0;
        int n;
        logic [DW-1:0] vals[$];

        rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("reset_outputs", 32'({rd_en, m_valid, m_sof, m_eof, busy, m_data}), 32'(0));
        check("reset_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        step();

        // Full burst of 16.
        base = rd_cnt;
        expect_frame(0, 16);
        write_words(0, 16);
        wait_drain(100, "t1_drain");
        @(negedge clk);
        check("t1_busy_low", 32'(busy), 32'(0));
        check("t1_rd_count", 32'(rd_cnt - base), 32'(16));
        step();

        // Timeout frame of 5; first beat 259 cycles after the first write.
        expect_frame(0, 5);
        c0 = cyc;
        write_words(0, 5);
        wait_drain(400, "t2_drain");
        check_range("t2_timeout_latency", last_sof_cyc - c0, 257, 262);

        // Flush frame of 3, then flush with an empty FIFO.
        expect_frame(0, 3);
        write_words(0, 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_drain(50, "t3_drain");
        base = rd_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (20) step();
        check("t3_empty_flush_rd", 32'(rd_cnt - base), 32'(0));
        check("t3_empty_flush_busy", 32'(busy), 32'(0));

        // Stalled burst of 16 then a timed-out residue of 4.
        expect_frame(0, 16);
        expect_frame(16, 4);
        toggle_on = 1'b1;
        write_words(0, 20);
        wait_drain(700, "t4_drain");
        toggle_on = 1'b0;
        step();

        // Full FIFO loaded under reset: level must read as 64.
        rst_n = 1'b0;
        step();
        write_words(0, 64);
        for (int f = 0; f < 4; f++) expect_frame(f * 16, 16);
        rst_n = 1'b1;
        wait_drain(400, "t5_drain");

        // Reset in the middle of a frame.
        base = beats_seen;
        expect_frame(0, 16);
        write_words(0, 16);
        n = 0;
        while (beats_seen - base < 8 && n < 200) begin
            step();
            n++;
        end
        check("t6_beats_before_reset", 32'(beats_seen - base), 32'(8));
        rst_n = 1'b0;
        step();
        check("t6_reset_outputs", 32'({rd_en, m_valid, m_sof, m_eof, busy, m_data}), 32'(0));
        check("t6_reset_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        exp_q.delete();
        vals = fifo_q;
        n = vals.size();
        check_range("t6_residue", n, 1, 15);
        for (int i = 0; i < 32 - n; i++) vals.push_back(DW'(100 + i));
        for (int i = 0; i < 32; i++) push_beat(vals[i], (i % 16 == 0), (i % 16 == 15));
        write_words(100, 32 - n);
        wait_drain(300, "t6_drain");

        check("no_rd_when_empty", 32'(rd_empty_err), 32'(0));
        check("no_fifo_overflow", 32'(wr_over_err), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
